// File: rtl/btn_conditioner.sv
// Button conditioner for a five-key front panel (menu, three speed keys, clean).
// Each key is synchronized, debounced with a stable-cycle counter, and turned
// into a single-cycle press pulse. Speed presses are kept one-hot; a same-edge
// double speed press is discarded. All outputs come straight from flops.

// One debounce channel: 2-flop synchronizer, debounced level and its counter.
module btn_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int CNT_W           = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    // Terminal count: the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_p0;
    logic             sync_p1;
    logic             deb;
    logic             deb_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Two-flop synchronizer; only sync_p1 is allowed into the debounce logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Count consecutive cycles where the synchronized input disagrees with the
    // debounced level; any agreeing cycle restarts the count, so glitches
    // shorter than the window never reach deb.
    always_comb begin
        deb_nxt = deb;
        cnt_nxt = '0;
        if (sync_p1 != deb) begin
            if (cnt == CNT_MAX) begin
                deb_nxt = sync_p1;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + CNT_ONE;
            end
        end
    end

    // Debounced level and counter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            deb <= deb_nxt;
            cnt <= cnt_nxt;
        end
    end

    assign level = deb;
    // High on the edge where deb is about to go 0->1; releases give nothing.
    assign rise  = deb_nxt & ~deb;

endmodule

// Top level: five identical channels plus pulse registers.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int CNT_W           = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       menu_raw,
    input  logic [2:0] speed_raw,
    input  logic       clean_raw,
    output logic       menu_btn,
    output logic [2:0] speed_btn,
    output logic       clean_btn,
    output logic [4:0] btn_level
);

    // Channel order matches btn_level: {clean, speed[2:0], menu}.
    logic [4:0] raw_vec;
    logic [4:0] level_vec;
    logic [4:0] rise_vec;
    logic       speed_multi;

    assign raw_vec = {clean_raw, speed_raw, menu_raw};

    for (genvar g = 0; g < 5; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_vec[g]),
            .level (level_vec[g]),
            .rise  (rise_vec[g])
        );
    end

    // Two or more speed keys accepted on the same edge is ambiguous.
    assign speed_multi = (rise_vec[1] & rise_vec[2]) |
                         (rise_vec[1] & rise_vec[3]) |
                         (rise_vec[2] & rise_vec[3]);

    // Register the press pulses so each is high for exactly the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            menu_btn  <= 1'b0;
            speed_btn <= 3'b000;
            clean_btn <= 1'b0;
        end else begin
            menu_btn  <= rise_vec[0];
            speed_btn <= speed_multi ? 3'b000 : rise_vec[3:1];
            clean_btn <= rise_vec[4];
        end
    end

    assign btn_level = level_vec;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with a 4-cycle debounce window. A sliding-window
// reference model tracks every edge; directed scenarios add fixed expectations.
module tb_btn_conditioner;

    localparam int DC = 4;

    logic       clk;
    logic       reset;
    logic       menu_raw;
    logic [2:0] speed_raw;
    logic       clean_raw;
    logic       menu_btn;
    logic [2:0] speed_btn;
    logic       clean_btn;
    logic [4:0] btn_level;

    int checks   = 0;
    int failures = 0;

    logic [4:0] hist[$];
    logic [4:0] m_deb;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .menu_raw  (menu_raw),
        .speed_raw (speed_raw),
        .clean_raw (clean_raw),
        .menu_btn  (menu_btn),
        .speed_btn (speed_btn),
        .clean_btn (clean_btn),
        .btn_level (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a channel's level flips once the last DC synchronized samples
    // (raw delayed two edges) all disagree with it.
    task automatic model_edge(input logic [4:0] raw, output logic [4:0] rise);
        int   n;
        int   idx;
        logic all_diff;
        logic v;
        hist.push_back(raw);
        n    = hist.size();
        rise = '0;
        for (int i = 0; i < 5; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DC; j++) begin
                idx = n - 3 - j;
                v   = (idx >= 0) ? hist[idx][i] : 1'b0;
                if (v == m_deb[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_deb[i] = ~m_deb[i];
                if (m_deb[i]) rise[i] = 1'b1;
            end
        end
    endtask

    task automatic tick(input logic [4:0] raw);
        logic [4:0] r;
        logic [2:0] sp;
        menu_raw  = raw[0];
        speed_raw = raw[3:1];
        clean_raw = raw[4];
        @(posedge clk);
        model_edge(raw, r);
        sp = ($countones(r[3:1]) >= 2) ? 3'b000 : r[3:1];
        #1;
        chk("menu_btn", 32'(menu_btn), 32'(r[0]));
        chk("speed_btn", 32'(speed_btn), 32'(sp));
        chk("clean_btn", 32'(clean_btn), 32'(r[4]));
        chk("btn_level", 32'(btn_level), 32'(m_deb));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        chk("rst_menu_btn", 32'(menu_btn), 32'd0);
        chk("rst_speed_btn", 32'(speed_btn), 32'd0);
        chk("rst_clean_btn", 32'(clean_btn), 32'd0);
        chk("rst_btn_level", 32'(btn_level), 32'd0);
        hist.delete();
        m_deb = '0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int         pulse_at;
        int         cnt_a;
        int         cnt_b;
        int         cnt_c;
        int         seen;
        logic [4:0] cur;

        reset     = 1'b1;
        menu_raw  = 1'b0;
        speed_raw = 3'b000;
        clean_raw = 1'b0;
        m_deb     = '0;
        #1;
        do_reset(2);

        // Menu press held: one pulse on the 6th edge, level stays high.
        pulse_at = 0;
        cnt_a    = 0;
        for (int t = 1; t <= 12; t++) begin
            tick(5'b00001);
            if (menu_btn) begin
                cnt_a++;
                if (pulse_at == 0) pulse_at = t;
            end
        end
        chk("menu_latency", 32'(pulse_at), 32'd6);
        chk("menu_pulse_count", 32'(cnt_a), 32'd1);
        chk("menu_level_held", 32'(btn_level[0]), 32'd1);

        // Release gives no pulse; a second press after 10 low cycles pulses.
        cnt_a = 0;
        for (int t = 0; t < 10; t++) begin
            tick(5'b00000);
            if (menu_btn) cnt_a++;
        end
        chk("release_no_pulse", 32'(cnt_a), 32'd0);
        chk("release_level", 32'(btn_level[0]), 32'd0);
        cnt_a = 0;
        for (int t = 0; t < 12; t++) begin
            tick(5'b00001);
            if (menu_btn) cnt_a++;
        end
        chk("repress_pulse_count", 32'(cnt_a), 32'd1);
        for (int t = 0; t < 10; t++) tick(5'b00000);

        // Bouncing menu key with 2-cycle runs never qualifies.
        cnt_a = 0;
        seen  = 0;
        for (int t = 0; t < 30; t++) begin
            tick((t < 20 && ((t / 2) % 2 == 0)) ? 5'b00001 : 5'b00000);
            if (menu_btn) cnt_a++;
            if (btn_level[0]) seen = 1;
        end
        chk("bounce_no_pulse", 32'(cnt_a), 32'd0);
        chk("bounce_level_low", 32'(seen), 32'd0);

        // Two speed keys accepted together: discarded, levels still follow.
        cnt_a = 0;
        for (int t = 0; t < 12; t++) begin
            tick(5'b00110);
            if (speed_btn != 3'b000) cnt_a++;
        end
        chk("dual_speed_no_pulse", 32'(cnt_a), 32'd0);
        chk("dual_speed_level", 32'(btn_level[2:1]), 32'd3);
        for (int t = 0; t < 10; t++) tick(5'b00000);

        // Speed 3 and clean together: both pulse in the same single cycle.
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        for (int t = 0; t < 12; t++) begin
            tick(5'b11000);
            if (speed_btn == 3'b100 && clean_btn) cnt_a++;
            if (speed_btn != 3'b000) cnt_b++;
            if (clean_btn) cnt_c++;
        end
        chk("speed_clean_coincident", 32'(cnt_a), 32'd1);
        chk("speed_clean_speed_count", 32'(cnt_b), 32'd1);
        chk("speed_clean_clean_count", 32'(cnt_c), 32'd1);
        for (int t = 0; t < 10; t++) tick(5'b00000);

        // Speed 2 pressed while speed 1 already held pulses its own bit.
        for (int t = 0; t < 10; t++) tick(5'b00010);
        cnt_a = 0;
        cnt_b = 0;
        for (int t = 0; t < 12; t++) begin
            tick(5'b00110);
            if (speed_btn == 3'b010) cnt_a++;
            if (speed_btn != 3'b000) cnt_b++;
        end
        chk("held_speed_bit2", 32'(cnt_a), 32'd1);
        chk("held_speed_any", 32'(cnt_b), 32'd1);
        for (int t = 0; t < 10; t++) tick(5'b00000);

        // Clean held, reset at count 2, full requalification after release.
        cnt_a = 0;
        for (int t = 0; t < 4; t++) begin
            tick(5'b10000);
            if (clean_btn) cnt_a++;
        end
        chk("clean_pre_reset_no_pulse", 32'(cnt_a), 32'd0);
        do_reset(1);
        pulse_at = 0;
        cnt_a    = 0;
        for (int t = 1; t <= 12; t++) begin
            tick(5'b10000);
            if (clean_btn) begin
                cnt_a++;
                if (pulse_at == 0) pulse_at = t;
            end
        end
        chk("clean_post_reset_latency", 32'(pulse_at), 32'd6);
        chk("clean_post_reset_count", 32'(cnt_a), 32'd1);
        for (int t = 0; t < 10; t++) tick(5'b00000);

        // Reset asserted during a pulse cycle drops the pulse at once.
        seen = 0;
        for (int t = 0; t < 12 && seen == 0; t++) begin
            tick(5'b00001);
            if (menu_btn) seen = 1;
        end
        chk("pulse_before_reset", 32'(seen), 32'd1);
        do_reset(1);
        for (int t = 0; t < 10; t++) tick(5'b00000);

        // Randomized key activity against the reference model.
        cur = '0;
        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 3) == 0) cur[$urandom_range(0, 4)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) cur[3:1] = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 249) == 0) do_reset(1);
            tick(cur);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 2000000 (20 ms at 100 MHz), legal range 2..2^21-1, giving the number of consecutive stable cycles required to accept a level change.
REQ-002 The block SHALL have parameter CNT_W, default 21, giving the debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; state clears immediately on falling edge, independent of clk.
REQ-005 menu_raw  input  1  raw, asynchronous, bouncing menu key; high = pressed.
REQ-006 speed_raw  input  3  raw speed keys: bit0 = speed 1, bit1 = speed 2, bit2 = speed 3; high = pressed.
REQ-007 clean_raw  input  1  raw self-clean key; high = pressed.
REQ-008 menu_btn  output  1  one-cycle pulse on each accepted menu press.
REQ-009 speed_btn  output  3  one-hot, one-cycle pulse; 000 = no event.
REQ-010 clean_btn  output  1  one-cycle pulse on each accepted clean press.
REQ-011 btn_level  output  5  debounced levels {clean, speed[2:0], menu}, for display/debug.

Function
REQ-012 Five identical channels SHALL be implemented: menu, speed0, speed1, speed2, clean.
REQ-013 Each channel SHALL pass its raw input through a 2-flop synchronizer; only the second flop output (sync) SHALL feed downstream logic.
REQ-014 Each channel SHALL hold a debounced level (deb) and a CNT_W-bit counter (cnt).
REQ-015 When sync == deb, cnt SHALL be cleared to 0.
REQ-016 When sync != deb and cnt < DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-017 When sync != deb and cnt == DEBOUNCE_CYCLES-1, deb SHALL take sync and cnt SHALL clear to 0 on that edge.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES stable cycles SHALL restart the count per REQ-015 and SHALL NOT change deb.
REQ-019 A channel rise event SHALL be the edge where deb goes 0->1; a registered pulse SHALL be high for exactly the one following cycle.
REQ-020 Falling deb (release) SHALL produce no pulse.
REQ-021 Latency: raw held high from before edge k SHALL produce a pulse high during the cycle after edge k+1+DEBOUNCE_CYCLES, then low.
REQ-022 Holding a key indefinitely SHALL produce exactly one pulse; no auto-repeat.
REQ-023 Speed one-hot rule: if two or more speed rise events occur on the same edge, speed_btn SHALL be 000 for that cycle, and those presses SHALL be discarded.
REQ-024 A single speed rise with other speed keys already held SHALL still pulse its own bit.
REQ-025 Menu, clean and speed pulses in the same cycle SHALL all be output unmodified; arbitration belongs downstream.
REQ-026 btn_level SHALL equal the current deb values, combinationally from registers.
REQ-027 All outputs SHALL be driven from flops; no combinational path from any raw input to any output.

Reset
REQ-028 While reset is low: sync flops, deb, cnt, pulse registers = 0; menu_btn = 0, speed_btn = 000, clean_btn = 0, btn_level = 00000.
REQ-029 Reset asserted mid-count SHALL discard the partial count; after release, a still-held key SHALL need a full 2+DEBOUNCE_CYCLES-edge qualification and SHALL then pulse once.
REQ-030 Reset asserted during a pulse cycle SHALL force the pulse low immediately.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 menu_raw 0->1 held high -> menu_btn high for exactly 1 cycle, 6 edges after first sampling; btn_level[0] = 1 thereafter; no further pulse.
REQ-032 menu_raw toggling 1,0,1,0 every 2 cycles for 20 cycles, then 0 -> menu_btn never high; btn_level[0] stays 0.
REQ-033 speed_raw 000->011 on the same cycle -> speed_btn stays 000; btn_level[2:1] = 11.
REQ-034 speed_raw 000->100 with clean_raw 0->1 on the same cycle -> speed_btn = 100 and clean_btn = 1 in the same single cycle.
REQ-035 clean_raw held high, reset pulsed low for 1 cycle at count 2, then released -> no pulse before reset; one clean_btn pulse 6 edges after release.
REQ-036 Key released, then pressed again after 10 low cycles -> second pulse produced; release itself produces none.
